// File: rtl/i2c_cmd_seq.sv
// Command sequencer for an I2C master: queues host commands, launches them one at a time, and collects read bytes.
// Define I2C_CMD_SEQ_TIMEOUT_EN to make an unanswered read complete with 8'hFF and set the sticky timeout_o.
module i2c_cmd_seq #(
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 2,
    parameter int TXN_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [23:0] cmd_data_i,
    output logic        start_ms_o,
    output logic [23:0] data_o,
    input  logic [7:0]  rxdata_i,
    input  logic        rxdone_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    input  logic        rsp_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [15:0] TXN_LOAD = 16'(TXN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;

    logic [23:0]       cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
    logic [CMD_AW:0]   cmd_count_reg, cmd_count_next;
    logic              cmd_ready_reg;
    logic              cmd_push, cmd_pop, cmd_head_rw;
    logic [23:0]       data_reg;

    logic [7:0]        rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wr_ptr_reg, rsp_rd_ptr_reg;
    logic [RSP_AW:0]   rsp_count_reg;
    logic              rsp_resv_reg;
    logic              rsp_push, rsp_pop;
    logic [7:0]        rsp_wdata;
    logic [RSP_AW+1:0] rsp_used;
    logic              rsp_has_room;

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    logic timeout_reg, timeout_next;
`endif

    // ---------------- command FIFO ----------------
    assign cmd_push    = cmd_valid_i && cmd_ready_reg;
    assign cmd_head_rw = cmd_mem[cmd_rd_ptr_reg][16];

    always_comb begin
        cmd_count_next = cmd_count_reg;
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_count_next = cmd_count_reg + (CMD_AW+1)'(1);
            2'b01:   cmd_count_next = cmd_count_reg - (CMD_AW+1)'(1);
            default: cmd_count_next = cmd_count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_reg] <= cmd_data_i;
        end
    end

    // Full is the extra count bit, since the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_wr_ptr_reg <= '0;
            cmd_rd_ptr_reg <= '0;
            cmd_count_reg  <= '0;
            cmd_ready_reg  <= 1'b0;
            data_reg       <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CMD_AW'(1);
            end
            if (cmd_pop) begin
                cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CMD_AW'(1);
                data_reg       <= cmd_mem[cmd_rd_ptr_reg];
            end
            cmd_count_reg <= cmd_count_next;
            cmd_ready_reg <= !cmd_count_next[CMD_AW];
        end
    end

    // ---------------- response FIFO ----------------
    assign rsp_valid_o  = (rsp_count_reg != '0);
    assign rsp_pop      = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o   = rsp_valid_o ? rsp_mem[rsp_rd_ptr_reg] : 8'h00;
    // A read in flight already owns a slot, so count it before launching another read.
    assign rsp_used     = {1'b0, rsp_count_reg} + (RSP_AW+2)'(rsp_resv_reg);
    assign rsp_has_room = rsp_used < (RSP_AW+2)'(RSP_DEPTH);

    always_ff @(posedge clk_i) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr_reg] <= rsp_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_wr_ptr_reg <= '0;
            rsp_rd_ptr_reg <= '0;
            rsp_count_reg  <= '0;
            rsp_resv_reg   <= 1'b0;
        end else begin
            if (rsp_push) begin
                rsp_wr_ptr_reg <= rsp_wr_ptr_reg + RSP_AW'(1);
            end
            if (rsp_pop) begin
                rsp_rd_ptr_reg <= rsp_rd_ptr_reg + RSP_AW'(1);
            end
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count_reg <= rsp_count_reg + (RSP_AW+1)'(1);
                2'b01:   rsp_count_reg <= rsp_count_reg - (RSP_AW+1)'(1);
                default: rsp_count_reg <= rsp_count_reg;
            endcase
            if (cmd_pop && cmd_head_rw) begin
                rsp_resv_reg <= 1'b1;
            end else if (rsp_push) begin
                rsp_resv_reg <= 1'b0;
            end
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
            timeout_reg <= timeout_next;
`endif
        end
    end

    // data_reg holds the transaction in flight, so its rw bit selects the completion rule.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cmd_pop    = 1'b0;
        rsp_push   = 1'b0;
        rsp_wdata  = rxdata_i;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
        timeout_next = timeout_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if ((cmd_count_reg != '0) && (!cmd_head_rw || rsp_has_room)) begin
                    cmd_pop    = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_next   = TXN_LOAD;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 16'd1;
                end
                if (data_reg[16]) begin
                    if (rxdone_i) begin
                        rsp_push   = 1'b1;
                        state_next = ST_GAP;
                    end
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
                    else if (cnt_reg == '0) begin
                        rsp_push     = 1'b1;
                        rsp_wdata    = 8'hFF;
                        timeout_next = 1'b1;
                        state_next   = ST_GAP;
                    end
`endif
                end else if (cnt_reg == '0) begin
                    state_next = ST_GAP;
                end
                if (state_next == ST_GAP) begin
                    cnt_next = 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready_o = cmd_ready_reg;
    assign start_ms_o  = (state_reg == ST_LAUNCH);
    assign busy_o      = (state_reg != ST_IDLE);
    assign data_o      = data_reg;

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Testbench for i2c_cmd_seq: directed scenarios followed by randomized transactions checked
// against a queue-based model of issue order, transaction length and response order.
module tb_i2c_cmd_seq;
    localparam int TXN = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [23:0] cmd_data_i;
    logic        start_ms_o;
    logic [23:0] data_o;
    logic [7:0]  rxdata_i;
    logic        rxdone_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_ready_i;
    logic        busy_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    i2c_cmd_seq #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (2),
        .TXN_CYCLES(TXN)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_data_i (cmd_data_i),
        .start_ms_o (start_ms_o),
        .data_o     (data_o),
        .rxdata_i   (rxdata_i),
        .rxdone_i   (rxdone_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .rsp_ready_i(rsp_ready_i),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_outs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 0);
        check({tag, "_start"}, start_ms_o, 0);
        check({tag, "_data_o"}, data_o, 0);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_rsp_data"}, rsp_data_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
    endtask

    task automatic push_cmd(input logic [23:0] w);
        int n;
        n = 0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = w;
        while (cmd_ready_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("cmd_accept", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 1;
        tick();
        while (start_ms_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("start_seen", start_ms_o, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", busy_o, 0);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rxdone_i = 1'b1;
        rxdata_i = d;
        tick();
        rxdone_i = 1'b0;
    endtask

    task automatic pop_rsp(input logic [7:0] exp, input string tag);
        check({tag, "_valid"}, rsp_valid_o, 1);
        check({tag, "_data"}, rsp_data_o, exp);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n, c, k, last;
        logic [23:0] w;
        logic [23:0] wq [5];
        logic [7:0]  d;
        logic        rd;
        logic [7:0]  exp_rsp [$];

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i = '0;
        rxdata_i = '0;
        rxdone_i = 1'b0;
        rsp_ready_i = 1'b0;
        repeat (3) tick();
        reset_outs("reset");
        rst_i = 1'b0;
        check("ready_before_edge", cmd_ready_o, 0);
        tick();
        check("ready_after_reset", cmd_ready_o, 1);

        // single write
        cmd_valid_i = 1'b1;
        cmd_data_i  = 24'hA0105A;
        tick();
        cmd_valid_i = 1'b0;
        check("wr_start_early", start_ms_o, 0);
        tick();
        check("wr_start", start_ms_o, 1);
        check("wr_data_o", data_o, 24'hA0105A);
        check("wr_busy", busy_o, 1);
        tick();
        check("wr_start_width", start_ms_o, 0);
        n = 1;
        while (busy_o === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("wr_busy_len", n, TXN + 3);
        check("wr_data_hold", data_o, 24'hA0105A);

        // single read, with an extra rxdone right after completion
        push_cmd(24'hA12000);
        wait_start(n);
        check("rd_launch_lat", n, 1);
        check("rd_data_o", data_o, 24'hA12000);
        repeat (5) tick();
        rxdone_i = 1'b1;
        rxdata_i = 8'h3C;
        tick();
        check("rd_rsp_valid", rsp_valid_o, 1);
        check("rd_rsp_data", rsp_data_o, 8'h3C);
        check("rd_timeout", timeout_o, 0);
        rxdata_i = 8'h77;
        tick();
        rxdone_i = 1'b0;
        wait_idle();
        pop_rsp(8'h3C, "rd_pop");
        check("rd_single_rsp", rsp_valid_o, 0);
        rx_pulse(8'h55);
        check("idle_rx_ignored", rsp_valid_o, 0);

        // fill the command FIFO while a write is in flight
        push_cmd(24'hB00001);
        wait_start(n);
        for (int i = 0; i < 5; i++) wq[i] = 24'hA03010 + 24'(i);
        for (int i = 0; i < 4; i++) push_cmd(wq[i]);
        check("full_ready_low", cmd_ready_o, 0);
        cmd_valid_i = 1'b1;
        cmd_data_i  = wq[4];
        n = 0;
        while (start_ms_o !== 1'b1 && n < 100) begin
            check("full_fifth_held", cmd_ready_o, 0);
            tick();
            n++;
        end
        check("full_w0_start", start_ms_o, 1);
        check("full_w0_data", data_o, wq[0]);
        check("full_ready_back", cmd_ready_o, 1);
        last = cyc;
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_start(n);
            check("full_order", data_o, wq[i]);
            check("full_spacing", (cyc - last) >= TXN + 3, 1);
            last = cyc;
        end
        wait_idle();
        check("full_empty_ready", cmd_ready_o, 1);

        // response backpressure: third read withheld until a pop
        push_cmd(24'hB00002);
        wait_start(n);
        push_cmd(24'hA14000);
        push_cmd(24'hA14100);
        push_cmd(24'hA14200);
        for (int j = 0; j < 2; j++) begin
            wait_start(n);
            check("bp_order", data_o, 24'hA14000 + 24'(j * 256));
            repeat (2) tick();
            rx_pulse(8'hD0 + 8'(j));
            wait_idle();
        end
        n = 0;
        for (int i = 0; i < 3 * TXN; i++) begin
            if (start_ms_o === 1'b1) n++;
            tick();
        end
        check("bp_withheld", n, 0);
        check("bp_busy", busy_o, 0);
        pop_rsp(8'hD0, "bp_pop0");
        wait_start(n);
        check("bp_release_lat", n, 1);
        check("bp_third_data", data_o, 24'hA14200);
        repeat (2) tick();
        rx_pulse(8'hD2);
        wait_idle();
        pop_rsp(8'hD1, "bp_pop1");
        pop_rsp(8'hD2, "bp_pop2");
        check("bp_drained", rsp_valid_o, 0);

        // read with no rxdone
        push_cmd(24'hA15000);
        wait_start(n);
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("to_latency", n, TXN + 1);
        check("to_rsp_data", rsp_data_o, 8'hFF);
        check("to_flag", timeout_o, 1);
        wait_idle();
        pop_rsp(8'hFF, "to_pop");
        repeat (3) tick();
        check("to_sticky", timeout_o, 1);
`else
        repeat (3 * TXN) tick();
        check("nto_busy", busy_o, 1);
        check("nto_rsp_valid", rsp_valid_o, 0);
        check("nto_flag", timeout_o, 0);
        rx_pulse(8'h5A);
        check("nto_late_rsp", rsp_valid_o, 1);
        wait_idle();
        pop_rsp(8'h5A, "nto_pop");
`endif

        // reset during a read wait
        push_cmd(24'hA16000);
        wait_start(n);
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        reset_outs("midrst");
        rst_i = 1'b0;
        tick();
        check("midrst_ready", cmd_ready_o, 1);
        rx_pulse(8'h99);
        check("midrst_rx_ignored", rsp_valid_o, 0);
        check("midrst_idle", busy_o, 0);

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            w  = 24'($urandom);
            rd = w[16];
            if (rd && exp_rsp.size() == 2) pop_rsp(exp_rsp.pop_front(), "rand_rsp");
            push_cmd(w);
            wait_start(n);
            check("rand_launch_lat", n, 1);
            check("rand_data_o", data_o, w);
            if ($urandom_range(0, 1) == 1) begin
                rxdone_i = 1'b1;
                rxdata_i = ~w[7:0];
            end
            tick();
            rxdone_i = 1'b0;
            c = 1;
            check("rand_start_width", start_ms_o, 0);
            k = $urandom_range(1, TXN - 1);
            while (c < k) begin
                tick();
                c++;
            end
            d = 8'($urandom);
            rx_pulse(d);
            c++;
            if (rd) exp_rsp.push_back(d);
            check("rand_rsp_present", rsp_valid_o, exp_rsp.size() != 0);
            while (busy_o === 1'b1 && c < 200) begin
                tick();
                c++;
            end
            check("rand_busy_len", c, rd ? k + 3 : TXN + 3);
            if (exp_rsp.size() != 0 && $urandom_range(0, 1) == 1)
                pop_rsp(exp_rsp.pop_front(), "rand_rsp");
        end
        while (exp_rsp.size() != 0) pop_rsp(exp_rsp.pop_front(), "drain_rsp");
        check("drain_empty", rsp_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
